// File: rtl/wf_ready_scheduler_pkg.sv
// Shared defaults and FSM encoding for the wavefront ready scheduler.
package wf_ready_scheduler_pkg;

    localparam int unsigned NUM_WF_DEF  = 40;
    localparam int unsigned WF_ID_W_DEF = 6;

    typedef enum logic {
        StIdle  = 1'b0,
        StOffer = 1'b1
    } wf_sched_state_e;

endpackage

// File: rtl/wf_ready_scheduler_rr_find_first.sv
// Combinational round-robin search: first set bit of i_mask at or above i_ptr, wrapping at NUM_WF.
module rr_find_first
    import wf_ready_scheduler_pkg::*;
#(
    parameter int unsigned NUM_WF  = NUM_WF_DEF,
    parameter int unsigned WF_ID_W = WF_ID_W_DEF
) (
    input  logic [NUM_WF-1:0]  i_mask,
    input  logic [WF_ID_W-1:0] i_ptr,
    output logic               o_found,
    output logic [WF_ID_W-1:0] o_index
);

    localparam logic [WF_ID_W:0] NumWfExt = (WF_ID_W + 1)'(NUM_WF);

    logic [WF_ID_W:0]   w_sum;
    logic [WF_ID_W-1:0] w_idx;

    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_WF; i++) begin
            w_sum = {1'b0, i_ptr} + (WF_ID_W + 1)'(i);
            if (w_sum >= NumWfExt) begin
                w_sum = w_sum - NumWfExt;
            end
            w_idx = w_sum[WF_ID_W-1:0];
            if (!o_found && i_mask[w_idx]) begin
                o_found = 1'b1;
                o_index = w_idx;
            end
        end
    end

endmodule

// File: rtl/wf_ready_scheduler.sv
// Per-wavefront ready-flag bank with a round-robin valid/ack issue arbiter.
// Optional protocol checker (proto_err) enabled by defining WF_SCHED_PROTO_CHECK_EN.
module wf_ready_scheduler
    import wf_ready_scheduler_pkg::*;
#(
    parameter int unsigned NUM_WF  = NUM_WF_DEF,
    parameter int unsigned WF_ID_W = WF_ID_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_valid,
    input  logic [WF_ID_W-1:0] set_wfid,
    input  logic               clr_valid,
    input  logic [WF_ID_W-1:0] clr_wfid,
    output logic               grant_valid,
    output logic [WF_ID_W-1:0] grant_wfid,
    input  logic               grant_ack,
`ifdef WF_SCHED_PROTO_CHECK_EN
    output logic               proto_err,
`endif
    output logic [NUM_WF-1:0]  ready_mask
);

    localparam logic [WF_ID_W:0]   NumWfExt = (WF_ID_W + 1)'(NUM_WF);
    localparam logic [WF_ID_W-1:0] LastWf   = WF_ID_W'(NUM_WF - 1);

    wf_sched_state_e    r_state;
    logic [WF_ID_W-1:0] r_ptr;
    logic               r_grant_valid;
    logic [WF_ID_W-1:0] r_grant_wfid;
    logic [NUM_WF-1:0]  r_ready;

    logic               w_set_ok, w_clr_ok, w_ack_hit, w_found;
    logic [WF_ID_W-1:0] w_found_idx;
    logic [NUM_WF-1:0]  w_set_vec, w_clr_vec, w_ack_vec, w_ready_d;

    assign w_set_ok  = set_valid && ({1'b0, set_wfid} < NumWfExt);
    assign w_clr_ok  = clr_valid && ({1'b0, clr_wfid} < NumWfExt);
    assign w_ack_hit = (r_state == StOffer) && grant_ack;

    assign w_set_vec = w_set_ok  ? (NUM_WF'(1) << set_wfid)     : '0;
    assign w_clr_vec = w_clr_ok  ? (NUM_WF'(1) << clr_wfid)     : '0;
    assign w_ack_vec = w_ack_hit ? (NUM_WF'(1) << r_grant_wfid) : '0;

    // Set wins over both clear sources on the same bit.
    assign w_ready_d = (r_ready & ~(w_clr_vec | w_ack_vec)) | w_set_vec;

    for (genvar g = 0; g < NUM_WF; g++) begin : g_ready_bit
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ready[g] <= 1'b1;
            end else begin
                r_ready[g] <= w_ready_d[g];
            end
        end
    end

    rr_find_first #(
        .NUM_WF  (NUM_WF),
        .WF_ID_W (WF_ID_W)
    ) u_rr_find_first (
        .i_mask  (r_ready),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_index (w_found_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_ptr         <= '0;
            r_grant_valid <= 1'b0;
            r_grant_wfid  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_grant_wfid  <= w_found_idx;
                        r_grant_valid <= 1'b1;
                        r_state       <= StOffer;
                    end
                end
                StOffer: begin
                    if (grant_ack) begin
                        r_ptr         <= (r_grant_wfid == LastWf) ? '0
                                                                  : r_grant_wfid + WF_ID_W'(1);
                        r_grant_valid <= 1'b0;
                        r_state       <= StIdle;
                    end else if (clr_valid && (clr_wfid == r_grant_wfid)) begin
                        // Halt of the offered wavefront withdraws the offer; pointer kept.
                        r_grant_valid <= 1'b0;
                        r_state       <= StIdle;
                    end
                end
                default: begin
                    r_grant_valid <= 1'b0;
                    r_state       <= StIdle;
                end
            endcase
        end
    end

`ifdef WF_SCHED_PROTO_CHECK_EN
    logic r_proto_err;
    logic w_err;

    assign w_err = (|(w_set_vec & r_ready & ~(w_clr_vec | w_ack_vec)))
                 || (grant_ack && !r_grant_valid)
                 || (set_valid && !w_set_ok)
                 || (clr_valid && !w_clr_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if (w_err) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err = r_proto_err;
`endif

    assign grant_valid = r_grant_valid;
    assign grant_wfid  = r_grant_wfid;
    assign ready_mask  = r_ready;

endmodule

// File: tb/tb_wf_ready_scheduler.sv
// Self-checking bench for wf_ready_scheduler: vector table, directed corner sequences and
// randomized traffic against a behavioural model. Checks proto_err when WF_SCHED_PROTO_CHECK_EN.
module tb_wf_ready_scheduler;

    localparam int NW = 40;
    localparam int IW = 6;
    localparam logic [NW-1:0] ALL1 = {NW{1'b1}};

    logic          clk = 1'b0;
    logic          rst;
    logic          set_valid, clr_valid, grant_ack;
    logic [IW-1:0] set_wfid, clr_wfid;
    logic          grant_valid;
    logic [IW-1:0] grant_wfid;
    logic [NW-1:0] ready_mask;
`ifdef WF_SCHED_PROTO_CHECK_EN
    logic          proto_err;
`endif

    wf_ready_scheduler #(.NUM_WF(NW), .WF_ID_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .set_valid   (set_valid),
        .set_wfid    (set_wfid),
        .clr_valid   (clr_valid),
        .clr_wfid    (clr_wfid),
        .grant_valid (grant_valid),
        .grant_wfid  (grant_wfid),
        .grant_ack   (grant_ack),
`ifdef WF_SCHED_PROTO_CHECK_EN
        .proto_err   (proto_err),
`endif
        .ready_mask  (ready_mask)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    bit [NW-1:0] m_ready;
    bit          m_off;
    int          m_gw;
    int          m_ptr;
    bit          m_perr;

    typedef struct {
        bit          sv;
        int          sid;
        bit          cv;
        int          cid;
        bit          ack;
        bit          egv;
        int          egw;
        logic [NW-1:0] emask;
        bit          eperr;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input bit gv, input int gw,
                         input logic [NW-1:0] mask, input bit perr);
        bit bad;
        tests++;
        bad = (grant_valid !== gv) || (gv && (grant_wfid !== IW'(gw))) || (ready_mask !== mask);
`ifdef WF_SCHED_PROTO_CHECK_EN
        if (proto_err !== perr) bad = 1'b1;
`else
        if (perr && 1'b0) bad = 1'b1;
`endif
        if (bad) begin
            fails++;
            $display("FAIL %s: got gv=%0b gw=%0d mask=%h, want gv=%0b gw=%0d mask=%h perr=%0b",
                     name, grant_valid, grant_wfid, ready_mask, gv, gw, mask, perr);
        end
    endtask

    task automatic model_reset();
        m_ready = ALL1;
        m_off   = 1'b0;
        m_gw    = 0;
        m_ptr   = 0;
        m_perr  = 1'b0;
    endtask

    task automatic model_step();
        bit [NW-1:0] nr;
        bit ackhit;
        int s, c;
        nr     = m_ready;
        ackhit = m_off && grant_ack;
        s      = int'(set_wfid);
        c      = int'(clr_wfid);
        if ((set_valid && s >= NW) || (clr_valid && c >= NW) || (grant_ack && !m_off))
            m_perr = 1'b1;
        if (set_valid && s < NW && m_ready[s] && !(clr_valid && c == s) && !(ackhit && m_gw == s))
            m_perr = 1'b1;
        if (ackhit) nr[m_gw] = 1'b0;
        if (clr_valid && c < NW) nr[c] = 1'b0;
        if (set_valid && s < NW) nr[s] = 1'b1;
        if (!m_off) begin
            for (int k = 0; k < NW; k++) begin
                if (!m_off && m_ready[(m_ptr + k) % NW]) begin
                    m_off = 1'b1;
                    m_gw  = (m_ptr + k) % NW;
                end
            end
        end else if (ackhit) begin
            m_off = 1'b0;
            m_ptr = (m_gw + 1) % NW;
        end else if (clr_valid && c == m_gw) begin
            m_off = 1'b0;
        end
        m_ready = nr;
    endtask

    task automatic idle_inputs();
        set_valid = 1'b0; set_wfid = '0;
        clr_valid = 1'b0; clr_wfid = '0;
        grant_ack = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic ack_once();
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
    endtask

    initial begin
        logic [NW-1:0] exp_mask;

        tbl[0]  = '{0, 0,  0, 0,  0, 1, 0, ALL1,            0};
        tbl[1]  = '{0, 0,  0, 0,  1, 0, 0, 40'hFF_FFFF_FFFE, 0};
        tbl[2]  = '{0, 0,  0, 0,  0, 1, 1, 40'hFF_FFFF_FFFE, 0};
        tbl[3]  = '{1, 1,  0, 0,  1, 0, 0, 40'hFF_FFFF_FFFE, 0};
        tbl[4]  = '{1, 45, 1, 63, 0, 1, 2, 40'hFF_FFFF_FFFE, 1};
        tbl[5]  = '{0, 0,  0, 0,  0, 1, 2, 40'hFF_FFFF_FFFE, 1};
        tbl[6]  = '{0, 0,  1, 2,  0, 0, 0, 40'hFF_FFFF_FFFA, 1};
        tbl[7]  = '{0, 0,  0, 0,  0, 1, 3, 40'hFF_FFFF_FFFA, 1};
        tbl[8]  = '{1, 0,  0, 0,  1, 0, 0, 40'hFF_FFFF_FFF3, 1};
        tbl[9]  = '{0, 0,  0, 0,  1, 1, 4, 40'hFF_FFFF_FFF3, 1};
        tbl[10] = '{1, 4,  1, 4,  0, 0, 0, 40'hFF_FFFF_FFF3, 1};
        tbl[11] = '{0, 0,  0, 0,  0, 1, 4, 40'hFF_FFFF_FFF3, 1};

        // Reset state, sampled while rst is held
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #2;
        check("reset_state", 1'b0, 0, ALL1, 1'b0);
        tests++;
        if (grant_wfid !== '0) begin
            fails++;
            $display("FAIL reset_wfid: got %0d want 0", grant_wfid);
        end

        // Vector table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_valid = tbl[i].sv; set_wfid = IW'(tbl[i].sid);
            clr_valid = tbl[i].cv; clr_wfid = IW'(tbl[i].cid);
            grant_ack = tbl[i].ack;
            tick();
            idle_inputs();
            check($sformatf("vec%0d", i), tbl[i].egv, tbl[i].egw, tbl[i].emask, tbl[i].eperr);
        end

        // Full sweep: offers 0..39 acked immediately
        do_reset();
        for (int i = 0; i < NW; i++) begin
            tick();
            exp_mask = ALL1 << i;
            check($sformatf("sweep_offer%0d", i), 1'b1, i, exp_mask, 1'b0);
            ack_once();
            exp_mask = ALL1 << (i + 1);
            check($sformatf("sweep_ack%0d", i), 1'b0, 0, exp_mask, 1'b0);
        end
        tick();
        tick();
        check("sweep_empty", 1'b0, 0, '0, 1'b0);

        // Wrap search from ptr=10 with 5 and 30 pending
        set_valid = 1'b1; set_wfid = 6'd9;
        tick();
        idle_inputs();
        tick();
        check("wrap_offer9", 1'b1, 9, 40'h00_0000_0200, 1'b0);
        set_valid = 1'b1; set_wfid = 6'd5;
        tick();
        set_wfid = 6'd30;
        tick();
        idle_inputs();
        ack_once();
        exp_mask = '0;
        exp_mask[5] = 1'b1;
        exp_mask[30] = 1'b1;
        check("wrap_ptr10", 1'b0, 0, exp_mask, 1'b0);
        tick();
        check("wrap_offer30", 1'b1, 30, exp_mask, 1'b0);
        ack_once();
        exp_mask[30] = 1'b0;
        tick();
        check("wrap_offer5", 1'b1, 5, exp_mask, 1'b0);

        // Offer held stable without ack, then withdrawn by clr
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            ack_once();
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold7_c%0d", i), 1'b1, 7, ALL1 << 7, 1'b0);
        end
        clr_valid = 1'b1; clr_wfid = 6'd7;
        tick();
        idle_inputs();
        exp_mask = ALL1 << 8;
        check("withdraw7", 1'b0, 0, exp_mask, 1'b0);
        tick();
        check("after_withdraw_8", 1'b1, 8, exp_mask, 1'b0);

        // Asynchronous reset mid-offer of wfid 3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            ack_once();
        end
        tick();
        check("pre_async_offer3", 1'b1, 3, ALL1 << 3, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset", 1'b0, 0, ALL1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("post_reset_offer0", 1'b1, 0, ALL1, 1'b0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            set_valid = ($urandom % 4) == 0;
            set_wfid  = (($urandom % 8) == 0) ? IW'($urandom_range(40, 63)) : IW'($urandom % NW);
            clr_valid = ($urandom % 6) == 0;
            clr_wfid  = (($urandom % 3) == 0) ? IW'(m_gw) : IW'($urandom % 64);
            grant_ack = ($urandom % 2) == 0;
            tick();
            idle_inputs();
            check("rand", m_off, m_gw, m_ready, m_perr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
